lsu_mem_ctrl: RTL and testbench

MEM-stage load/store controller.
- Accepts one load/store per instruction from the EX/MEM register.
- Drives a word-aligned valid/ready data-memory port and generates byte enables and lane-replicated store data.
- Waits out memory wait states while stalling the pipeline.
- Right-aligns returned load data by address offset and feeds it to the downstream load-format (sign/zero-extend) stage that produces the writeback value.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_lane_align.sv | 39 +++
 rtl/lsu_mem_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and encodings for the MEM-stage load/store controller.
package lsu_pkg;

    localparam int BE_W = 4;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_R,
        ST_DONE
    } lsu_state_e;

    // Size 2'b11 is handled as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: byte enables, replicated store data, misalign
// detection and right-alignment of returned load words.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]      i_size,
    input  logic [1:0]      i_off,
    input  logic [31:0]     i_st_data,
    input  logic [1:0]      i_ld_off,
    input  logic [31:0]     i_rdata,
    output logic [BE_W-1:0] o_be,
    output logic [31:0]     o_wdata,
    output logic            o_misalign,
    output logic [31:0]     o_ld_shifted
);

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_st_data;
        case (i_size)
            SZ_B: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {4{i_st_data[7:0]}};
            end
            SZ_H: begin
                o_be    = 4'b0011 << i_off;
                o_wdata = {2{i_st_data[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_st_data;
            end
        endcase
    end

    assign o_misalign   = is_misaligned(i_size, i_off);
    assign o_ld_shifted = i_rdata >> {i_ld_off, 3'b000};

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store controller driving a valid/ready data-memory port.
// Optional wait-state timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_st_data,
    input  logic [1:0]        i_size,
    output logic              o_stall,
    output logic [31:0]       o_ld_data,
    output logic              o_ld_valid,
    output logic              o_misalign,
    output logic              o_timeout,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [BE_W-1:0]   o_mem_be,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_ready,
    input  logic              i_mem_rvalid,
    input  logic [31:0]       i_mem_rdata
);

    lsu_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [BE_W-1:0]   mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       ld_data_q, ld_data_d;
    logic              ld_valid_q, ld_valid_d;
    logic              misalign_q, misalign_d;
    logic              timeout_q, timeout_d;

    logic [BE_W-1:0]   al_be;
    logic [31:0]       al_wdata;
    logic              al_misalign;
    logic [31:0]       al_ld_shifted;
    logic              wait_expired;

    lsu_lane_align u_align (
        .i_size       (i_size),
        .i_off        (i_addr[1:0]),
        .i_st_data    (i_st_data),
        .i_ld_off     (off_q),
        .i_rdata      (i_mem_rdata),
        .o_be         (al_be),
        .o_wdata      (al_wdata),
        .o_misalign   (al_misalign),
        .o_ld_shifted (al_ld_shifted)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    assign wait_expired = (wait_cnt_q == CNT_W'(MAX_WAIT - 1));

    // Counts cycles spent in the current REQ/WAIT_R visit; any entry restarts it.
    always_comb begin
        wait_cnt_d = '0;
        if ((state_d == ST_REQ || state_d == ST_WAIT_R) && state_d == state_q) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end
`else
    assign wait_expired = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        off_d       = off_q;
        ld_data_d   = ld_data_q;
        ld_valid_d  = 1'b0;
        misalign_d  = 1'b0;
        timeout_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_req) begin
                    if (al_misalign) begin
                        misalign_d = 1'b1;
                    end else begin
                        mem_we_d    = i_we;
                        off_d       = i_addr[1:0];
                        mem_addr_d  = {i_addr[ADDR_W-1:2], 2'b00};
                        mem_be_d    = al_be;
                        mem_wdata_d = al_wdata;
                        mem_req_d   = 1'b1;
                        state_d     = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (i_mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = mem_we_q ? ST_DONE : ST_WAIT_R;
                end else if (wait_expired) begin
                    mem_req_d = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                    if (!mem_we_q) begin
                        ld_data_d  = '0;
                        ld_valid_d = 1'b1;
                    end
                end
            end
            ST_WAIT_R: begin
                if (i_mem_rvalid) begin
                    ld_data_d  = al_ld_shifted;
                    ld_valid_d = 1'b1;
                    state_d    = ST_DONE;
                end else if (wait_expired) begin
                    ld_data_d  = '0;
                    ld_valid_d = 1'b1;
                    timeout_d  = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            off_q       <= '0;
            ld_data_q   <= '0;
            ld_valid_q  <= 1'b0;
            misalign_q  <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            off_q       <= off_d;
            ld_data_q   <= ld_data_d;
            ld_valid_q  <= ld_valid_d;
            misalign_q  <= misalign_d;
            timeout_q   <= timeout_d;
`ifdef LSU_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    // Stall is held low during reset even if the state register has not yet cleared.
    assign o_stall = !i_reset &&
                     ((state_q == ST_IDLE && i_req && !al_misalign) ||
                      state_q == ST_REQ || state_q == ST_WAIT_R);

    assign o_ld_data   = ld_data_q;
    assign o_ld_valid  = ld_valid_q;
    assign o_misalign  = misalign_q;
    assign o_timeout   = timeout_q;
    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_be    = mem_be_q;
    assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed scenarios plus randomized
// transactions against a byte-level reference model.
module tb_lsu_mem_ctrl;

    localparam int ADDR_W   = 32;
    localparam int MAX_WAIT = 16;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_req;
    logic        i_we;
    logic [31:0] i_addr;
    logic [31:0] i_st_data;
    logic [1:0]  i_size;
    logic        o_stall;
    logic [31:0] o_ld_data;
    logic        o_ld_valid;
    logic        o_misalign;
    logic        o_timeout;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ready;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] last_ld;
    logic [31:0] mem_model [logic [31:0]];

    always #5 i_clk = ~i_clk;

    lsu_mem_ctrl #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_req        (i_req),
        .i_we         (i_we),
        .i_addr       (i_addr),
        .i_st_data    (i_st_data),
        .i_size       (i_size),
        .o_stall      (o_stall),
        .o_ld_data    (o_ld_data),
        .o_ld_valid   (o_ld_valid),
        .o_misalign   (o_misalign),
        .o_timeout    (o_timeout),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_be     (o_mem_be),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_ready  (i_mem_ready),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata)
    );

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        if (sz == 2'b00) return 1;
        if (sz == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic exp_misalign(input logic [1:0] sz, input logic [31:0] a);
        return (int'(a % 4) % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
        int n = nbytes(sz);
        int base = (n == 4) ? 0 : int'(a % 4);
        logic [3:0] be = '0;
        for (int i = 0; i < 4; i++) if (i >= base && i < base + n) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] d);
        int n = nbytes(sz);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
        return w;
    endfunction

    task automatic drive_idle;
        i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_st_data = '0; i_size = 2'b00;
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    endtask

    task automatic idle_cycle(input string name);
        drive_idle();
        #1;
        total++;
        if (o_ld_valid !== 1'b0 || o_stall !== 1'b0 || o_misalign !== 1'b0 ||
            o_timeout !== 1'b0 || o_mem_req !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle: ld_valid=%b stall=%b misalign=%b timeout=%b mem_req=%b want all 0",
                     name, o_ld_valid, o_stall, o_misalign, o_timeout, o_mem_req);
        end
        tick();
    endtask

    // Full transaction: rdly extra REQ cycles before ready, vdly extra WAIT_R cycles before rvalid.
    task automatic do_txn(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] data, input logic [1:0] sz,
                          input int rdly, input int vdly, input logic [31:0] rword);
        int stalls = 0;
        int exp_stalls;
        logic [31:0] wa = {addr[31:2], 2'b00};
        logic [3:0]  be_e = exp_be(sz, addr);
        logic [31:0] wd_e = exp_wdata(sz, data);
        logic [31:0] old;

        i_req = 1'b1; i_we = we; i_addr = addr; i_st_data = data; i_size = sz;
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
        #1;
        total++;
        if (o_ld_valid !== 1'b0 || o_ld_data !== last_ld) begin
            bad++;
            $display("FAIL %s_accept: ld_valid=%b ld_data=%h want 0 %h", name, o_ld_valid, o_ld_data, last_ld);
        end
        if (o_stall === 1'b1) stalls++;
        tick();
        i_addr = $urandom; i_st_data = $urandom;

        for (int c = 0; c <= rdly; c++) begin
            i_mem_ready  = (c == rdly);
            i_mem_rvalid = 1'($urandom_range(0, 1));
            i_mem_rdata  = $urandom;
            #1;
            total++;
            if (o_mem_req !== 1'b1 || o_mem_we !== we || o_mem_addr !== wa ||
                o_mem_be !== be_e || o_mem_wdata !== wd_e) begin
                bad++;
                $display("FAIL %s_req%0d: req=%b we=%b addr=%h be=%b wdata=%h want 1 %b %h %b %h",
                         name, c, o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
                         we, wa, be_e, wd_e);
            end
            if (o_stall === 1'b1) stalls++;
            tick();
        end
        i_mem_ready = 1'b0;
        i_mem_rvalid = 1'b0;

        if (!we) begin
            for (int c = 0; c <= vdly; c++) begin
                i_mem_rvalid = (c == vdly);
                i_mem_rdata  = (c == vdly) ? rword : $urandom;
                i_mem_ready  = 1'($urandom_range(0, 1));
                #1;
                total++;
                if (o_mem_req !== 1'b0) begin
                    bad++;
                    $display("FAIL %s_waitr%0d: mem_req=%b want 0", name, c, o_mem_req);
                end
                if (o_stall === 1'b1) stalls++;
                tick();
            end
            i_mem_rvalid = 1'b0; i_mem_ready = 1'b0;
            last_ld = rword >> (8 * int'(addr % 4));
            exp_stalls = 3 + rdly + vdly;
        end else begin
            old = mem_model.exists(wa) ? mem_model[wa] : 32'h0;
            for (int i = 0; i < 4; i++) if (be_e[i]) old[8*i +: 8] = wd_e[8*i +: 8];
            mem_model[wa] = old;
            exp_stalls = 2 + rdly;
        end

        #1;
        total++;
        if (o_stall !== 1'b0 || o_ld_valid !== !we || o_ld_data !== last_ld ||
            o_timeout !== 1'b0 || o_mem_req !== 1'b0) begin
            bad++;
            $display("FAIL %s_done: stall=%b ld_valid=%b ld_data=%h timeout=%b req=%b want 0 %b %h 0 0",
                     name, o_stall, o_ld_valid, o_ld_data, o_timeout, o_mem_req, !we, last_ld);
        end
        total++;
        if (stalls != exp_stalls) begin
            bad++;
            $display("FAIL %s_stalls: got %0d want %0d", name, stalls, exp_stalls);
        end
        tick();
    endtask

    task automatic test_reset;
        drive_idle();
        i_reset = 1'b1;
        i_req = 1'b1; i_size = 2'b10; i_addr = 32'h100;
        tick();
        tick();
        total++;
        if (o_stall !== 1'b0 || o_ld_data !== '0 || o_ld_valid !== 1'b0 || o_misalign !== 1'b0 ||
            o_timeout !== 1'b0 || o_mem_req !== 1'b0 || o_mem_we !== 1'b0 ||
            o_mem_addr !== '0 || o_mem_be !== '0 || o_mem_wdata !== '0) begin
            bad++;
            $display("FAIL reset_state: stall=%b ld=%h v=%b mis=%b to=%b req=%b we=%b addr=%h be=%b wd=%h want all 0",
                     o_stall, o_ld_data, o_ld_valid, o_misalign, o_timeout, o_mem_req, o_mem_we,
                     o_mem_addr, o_mem_be, o_mem_wdata);
        end
        i_reset = 1'b0;
        last_ld = '0;
        idle_cycle("reset");
    endtask

    task automatic test_misalign;
        logic [31:0] a;
        logic [1:0]  sz;
        for (int k = 0; k < 6; k++) begin
            if (k == 0) begin
                a = 32'h3001; sz = 2'b10;
            end else begin
                do begin
                    a = 32'h3000 + 32'($urandom_range(0, 63));
                    sz = 2'($urandom_range(1, 3));
                end while (!exp_misalign(sz, a));
            end
            i_req = 1'b1; i_we = 1'($urandom_range(0, 1)); i_addr = a; i_size = sz;
            i_st_data = $urandom;
            #1;
            total++;
            if (o_stall !== 1'b0 || o_mem_req !== 1'b0) begin
                bad++;
                $display("FAIL misalign%0d_issue: stall=%b mem_req=%b want 0 0", k, o_stall, o_mem_req);
            end
            tick();
            drive_idle();
            #1;
            total++;
            if (o_misalign !== 1'b1 || o_mem_req !== 1'b0 || o_stall !== 1'b0) begin
                bad++;
                $display("FAIL misalign%0d_pulse: misalign=%b req=%b stall=%b want 1 0 0",
                         k, o_misalign, o_mem_req, o_stall);
            end
            tick();
            idle_cycle("misalign_end");
        end
    endtask

    task automatic test_timeout;
`ifdef LSU_TIMEOUT_EN
        int reqc = 0;
        logic seen = 1'b0;
        i_req = 1'b1; i_we = 1'b0; i_addr = 32'h6004; i_size = 2'b10;
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
        tick();
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            if (o_timeout === 1'b1) seen = 1'b1;
            else begin
                if (o_mem_req === 1'b1) reqc++;
                tick();
            end
        end
        total++;
        if (!seen || reqc != MAX_WAIT || o_ld_data !== '0 || o_ld_valid !== 1'b1 ||
            o_stall !== 1'b0 || o_mem_req !== 1'b0) begin
            bad++;
            $display("FAIL timeout_req: seen=%b reqc=%0d ld=%h v=%b stall=%b req=%b want 1 %0d 0 1 0 0",
                     seen, reqc, o_ld_data, o_ld_valid, o_stall, o_mem_req, MAX_WAIT);
        end
        last_ld = '0;
        tick();
        idle_cycle("timeout_req");
        // WAIT_R timeout: ready at once, no rvalid.
        seen = 1'b0; reqc = 0;
        i_req = 1'b1; i_we = 1'b0; i_addr = 32'h6008; i_size = 2'b10;
        tick();
        i_mem_ready = 1'b1;
        tick();
        i_mem_ready = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            if (o_timeout === 1'b1) seen = 1'b1;
            else begin
                if (o_stall === 1'b1) reqc++;
                tick();
            end
        end
        total++;
        if (!seen || reqc != MAX_WAIT || o_ld_valid !== 1'b1 || o_ld_data !== '0) begin
            bad++;
            $display("FAIL timeout_waitr: seen=%b cycles=%0d v=%b ld=%h want 1 %0d 1 0",
                     seen, reqc, o_ld_valid, o_ld_data, MAX_WAIT);
        end
        tick();
        idle_cycle("timeout_waitr");
`else
        int stall_ok = 0;
        int to_seen = 0;
        i_req = 1'b1; i_we = 1'b0; i_addr = 32'h6004; i_size = 2'b10;
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
        tick();
        for (int c = 0; c < 20; c++) begin
            #1;
            if (o_stall === 1'b1 && o_mem_req === 1'b1) stall_ok++;
            if (o_timeout !== 1'b0) to_seen++;
            tick();
        end
        total++;
        if (stall_ok != 20 || to_seen != 0) begin
            bad++;
            $display("FAIL no_timeout_hold: stall_req_cycles=%0d timeout_cycles=%0d want 20 0",
                     stall_ok, to_seen);
        end
        i_mem_ready = 1'b1;
        tick();
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hCAFEF00D;
        tick();
        i_mem_rvalid = 1'b0;
        #1;
        total++;
        if (o_ld_valid !== 1'b1 || o_ld_data !== 32'hCAFEF00D || o_timeout !== 1'b0) begin
            bad++;
            $display("FAIL no_timeout_done: v=%b ld=%h to=%b want 1 cafef00d 0", o_ld_valid, o_ld_data, o_timeout);
        end
        last_ld = 32'hCAFEF00D;
        tick();
        idle_cycle("no_timeout");
`endif
    endtask

    task automatic test_reset_mid;
        i_req = 1'b1; i_we = 1'b0; i_addr = 32'h5000; i_size = 2'b10;
        tick();
        i_mem_ready = 1'b1;
        tick();
        i_mem_ready = 1'b0;
        i_reset = 1'b1;
        #1;
        total++;
        if (o_stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_stall: stall=%b want 0", o_stall);
        end
        tick();
        i_reset = 1'b0; i_req = 1'b0;
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'hDEADBEEF;
        last_ld = '0;
        #1;
        total++;
        if (o_ld_data !== '0 || o_ld_valid !== 1'b0 || o_mem_req !== 1'b0 || o_stall !== 1'b0 ||
            o_mem_addr !== '0 || o_mem_be !== '0 || o_mem_wdata !== '0) begin
            bad++;
            $display("FAIL reset_mid_state: ld=%h v=%b req=%b stall=%b addr=%h be=%b wd=%h want all 0",
                     o_ld_data, o_ld_valid, o_mem_req, o_stall, o_mem_addr, o_mem_be, o_mem_wdata);
        end
        tick();
        i_mem_rvalid = 1'b0;
        #1;
        total++;
        if (o_ld_valid !== 1'b0 || o_ld_data !== '0) begin
            bad++;
            $display("FAIL reset_mid_rvalid: v=%b ld=%h want 0 0", o_ld_valid, o_ld_data);
        end
        tick();
        idle_cycle("reset_mid");
    endtask

    task automatic test_back_to_back;
        do_txn("b2b_st", 1'b1, 32'h4000, 32'h11223344, 2'b10, 0, 0, 32'h0);
        do_txn("b2b_ld", 1'b0, 32'h4001, 32'h0, 2'b00, 0, 0, mem_model[32'h4000]);
        total++;
        if (o_ld_data !== 32'h00112233) begin
            bad++;
            $display("FAIL b2b_value: ld=%h want 00112233", o_ld_data);
        end
        idle_cycle("b2b");
    endtask

    task automatic test_random;
        logic        we;
        logic [1:0]  sz;
        logic [31:0] a, wa, rw;
        for (int k = 0; k < 40; k++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = 32'h8000 + 32'($urandom_range(0, 31));
            a  = a - (a % 32'(nbytes(sz)));
            wa = {a[31:2], 2'b00};
            rw = mem_model.exists(wa) ? mem_model[wa] : $urandom;
            do_txn("rand", we, a, $urandom, sz, $urandom_range(0, 4), $urandom_range(0, 4), rw);
            if ($urandom_range(0, 1) == 1) idle_cycle("rand");
        end
        idle_cycle("rand_end");
    endtask

    initial begin
        drive_idle();
        i_reset = 1'b1;
        last_ld = '0;
        test_reset();
        do_txn("st_byte", 1'b1, 32'h1003, 32'h000000A5, 2'b00, 0, 0, 32'h0);
        idle_cycle("st_byte");
        do_txn("ld_half", 1'b0, 32'h2002, 32'h0, 2'b01, 0, 2, 32'hBEEF1234);
        total++;
        if (o_ld_data !== 32'h0000BEEF) begin
            bad++;
            $display("FAIL ld_half_value: ld=%h want 0000beef", o_ld_data);
        end
        idle_cycle("ld_half");
        test_misalign();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
